// File: rtl/hit_window_timer.sv
// Multi-lane note hit-window timer. Each lane arms on a spawn pulse, counts
// en-qualified cycles through a programmable window and resolves either to a
// graded HIT on a button press or to a MISS on timeout. Saturating hit/miss
// totals are kept across all lanes.
module hit_window_timer #(
  parameter int unsigned LANES   = 4,
  parameter int unsigned CNT_W   = 26,
  parameter int unsigned SCORE_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [LANES-1:0]     start,
  input  logic [LANES-1:0]     btn,
  input  logic [CNT_W-1:0]     window_len,
  input  logic [CNT_W-1:0]     perf_lo,
  input  logic [CNT_W-1:0]     perf_hi,
  input  logic                 clr_stats,
  output logic [LANES-1:0]     busy,
  output logic [LANES-1:0]     hit,
  output logic [LANES-1:0]     miss,
  output logic [2*LANES-1:0]   grade,
  output logic [SCORE_W-1:0]   hit_total,
  output logic [SCORE_W-1:0]   miss_total
);

  typedef enum logic {StIdle, StArmed} state_e;

  localparam logic [1:0] GradeEarly   = 2'b01;
  localparam logic [1:0] GradePerfect = 2'b10;
  localparam logic [1:0] GradeLate    = 2'b11;

  state_e                 state_q [LANES];
  state_e                 state_d [LANES];
  logic [CNT_W-1:0]       count_q [LANES];
  logic [CNT_W-1:0]       count_d [LANES];
  logic [LANES-1:0]       hit_q, hit_d;
  logic [LANES-1:0]       miss_q, miss_d;
  logic [2*LANES-1:0]     grade_q, grade_d;
  logic [SCORE_W-1:0]     hit_total_q, hit_total_d;
  logic [SCORE_W-1:0]     miss_total_q, miss_total_d;

  // perf_lo > perf_hi leaves no perfect band: anything at/after perf_lo is late.
  function automatic logic [1:0] grade_of(input logic [CNT_W-1:0] cnt,
                                          input logic [CNT_W-1:0] lo,
                                          input logic [CNT_W-1:0] hi);
    if (cnt < lo)       return GradeEarly;
    else if (cnt <= hi) return GradePerfect;
    else                return GradeLate;
  endfunction

  function automatic logic [SCORE_W:0] popcount(input logic [LANES-1:0] v);
    logic [SCORE_W:0] c;
    c = '0;
    for (int i = 0; i < LANES; i++) c = c + {{SCORE_W{1'b0}}, v[i]};
    return c;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W:0]   b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + b;
    return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
  endfunction

  // Per-lane next-state: arm, count, resolve. A press always beats timeout
  // and retrigger, so hit and miss can never coincide on one lane.
  always_comb begin
    hit_d   = '0;
    miss_d  = '0;
    grade_d = '0;
    for (int i = 0; i < LANES; i++) begin
      state_d[i] = state_q[i];
      count_d[i] = count_q[i];
      unique case (state_q[i])
        StIdle: begin
          if (start[i]) begin
            state_d[i] = StArmed;
            count_d[i] = '0;
          end
        end
        StArmed: begin
          if (btn[i]) begin
            hit_d[i]           = 1'b1;
            grade_d[2*i +: 2]  = grade_of(count_q[i], perf_lo, perf_hi);
            state_d[i]         = start[i] ? StArmed : StIdle;
            count_d[i]         = '0;
          end else if (start[i]) begin
            miss_d[i]  = 1'b1;
            count_d[i] = '0;
          end else if (en) begin
            // >= guards against window_len shrinking below a running count.
            if (count_q[i] >= window_len) begin
              miss_d[i]  = 1'b1;
              state_d[i] = StIdle;
              count_d[i] = '0;
            end else begin
              count_d[i] = count_q[i] + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d[i] = StIdle;
          count_d[i] = '0;
        end
      endcase
    end
  end

  // Totals accumulate the registered pulses; a clear drops any same-cycle increment.
  always_comb begin
    hit_total_d  = sat_add(hit_total_q, popcount(hit_q));
    miss_total_d = sat_add(miss_total_q, popcount(miss_q));
    if (clr_stats) begin
      hit_total_d  = '0;
      miss_total_d = '0;
    end
  end

  // State, counters, output pulses and totals.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LANES; i++) begin
        state_q[i] <= StIdle;
        count_q[i] <= '0;
      end
      hit_q        <= '0;
      miss_q       <= '0;
      grade_q      <= '0;
      hit_total_q  <= '0;
      miss_total_q <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        state_q[i] <= state_d[i];
        count_q[i] <= count_d[i];
      end
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      grade_q      <= grade_d;
      hit_total_q  <= hit_total_d;
      miss_total_q <= miss_total_d;
    end
  end

  // Busy is a direct decode of the registered lane state.
  always_comb begin
    busy = '0;
    for (int i = 0; i < LANES; i++) busy[i] = (state_q[i] == StArmed);
  end

  assign hit        = hit_q;
  assign miss       = miss_q;
  assign grade      = grade_q;
  assign hit_total  = hit_total_q;
  assign miss_total = miss_total_q;

endmodule
